// File: rtl/temperature_alarm_controller_pkg.sv
// Shared types and default parameters for the temperature alarm controller.
package temperature_alarm_controller_pkg;

   // Controller states; the encoding is fixed so external tools can decode it.
   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      SUSPECT = 2'd1,
      ALARM   = 2'd2,
      RECOVER = 2'd3
   } state_e;

   // Defaults shared by the top level and the bench so both agree.
   localparam int DEF_CONFIRM_COUNT = 3;
   localparam int DEF_CLEAR_COUNT   = 4;
   localparam int DEF_CNT_W         = 4;
   localparam int DEF_EVT_W         = 8;

endpackage

// File: rtl/temperature_alarm_controller_if.sv
// Sample/acknowledge inputs and alarm status outputs of the controller.
interface temperature_alarm_controller_if
   import temperature_alarm_controller_pkg::*;
   #(parameter int EVT_W = DEF_EVT_W) ();

   logic             sampleValid;
   logic             tempAbnormality;
   logic             alarmAck;
   logic             alarm;
   logic             alarmEvent;
   logic             clearReady;
   logic [EVT_W-1:0] eventCount;

   // Upstream/operator side: drives samples and ack, observes status.
   modport master (
      output sampleValid, tempAbnormality, alarmAck,
      input  alarm, alarmEvent, clearReady, eventCount
   );

   // Controller side.
   modport slave (
      input  sampleValid, tempAbnormality, alarmAck,
      output alarm, alarmEvent, clearReady, eventCount
   );

endinterface

// File: rtl/temperature_alarm_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/temperature_alarm_controller.sv
// Debounced, latched temperature alarm with operator-acknowledged release
// and a saturating count of alarm rises.
module temperature_alarm_controller
   import temperature_alarm_controller_pkg::*;
#(
   parameter int CONFIRM_COUNT = DEF_CONFIRM_COUNT,
   parameter int CLEAR_COUNT   = DEF_CLEAR_COUNT,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int EVT_W         = DEF_EVT_W
) (
   input  logic                            clk,
   input  logic                            rst,
   temperature_alarm_controller_if.slave   bus
);

   localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM_COUNT);
   localparam logic [CNT_W-1:0] CLEAR_C   = CNT_W'(CLEAR_COUNT);

   state_e           state_q, state_d;
   logic             alarm_q, alarm_d;
   logic             event_q, event_d;
   logic             ready_q, ready_d;
   logic             run_inc, run_clr, raise;
   logic [CNT_W-1:0] run_cnt, run_nxt;
   logic [EVT_W-1:0] event_cnt;
   logic             v_abn, v_norm;

   assign v_abn   = bus.sampleValid &  bus.tempAbnormality;
   assign v_norm  = bus.sampleValid & ~bus.tempAbnormality;
   assign run_nxt = run_cnt + CNT_W'(1);

   // Length of the current abnormal (confirming) or normal (clearing) run.
   sat_counter #(.W(CNT_W)) u_run_cnt (
      .clk (clk),
      .rst (rst),
      .inc (run_inc),
      .clr (run_clr),
      .cnt (run_cnt)
   );

   // Alarm rises since reset; sticks at its maximum.
   sat_counter #(.W(EVT_W)) u_event_cnt (
      .clk (clk),
      .rst (rst),
      .inc (raise),
      .clr (1'b0),
      .cnt (event_cnt)
   );

   // Next state, run-counter control and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      run_inc = 1'b0;
      run_clr = 1'b0;
      raise   = 1'b0;
      unique case (state_q)
         NORMAL: begin
            // run counter is always 0 here, so an increment yields 1
            if (v_abn) begin
               if (CONFIRM_COUNT == 1) begin
                  state_d = ALARM;
                  raise   = 1'b1;
                  run_clr = 1'b1;
               end else begin
                  state_d = SUSPECT;
                  run_inc = 1'b1;
               end
            end
         end
         SUSPECT: begin
            if (v_abn) begin
               if (run_nxt == CONFIRM_C) begin
                  state_d = ALARM;
                  raise   = 1'b1;
                  run_clr = 1'b1;
               end else begin
                  run_inc = 1'b1;
               end
            end else if (v_norm) begin
               state_d = NORMAL;
               run_clr = 1'b1;
            end
         end
         ALARM: begin
            // ack is deliberately ignored until the condition has cleared
            if (v_norm) begin
               if (run_nxt == CLEAR_C) begin
                  state_d = RECOVER;
                  run_clr = 1'b1;
               end else begin
                  run_inc = 1'b1;
               end
            end else if (v_abn) begin
               run_clr = 1'b1;
            end
         end
         RECOVER: begin
            // abnormality beats a simultaneous ack; re-entry is not a new event
            if (v_abn) begin
               state_d = ALARM;
               run_clr = 1'b1;
            end else if (bus.alarmAck) begin
               state_d = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase
      alarm_d = (state_d == ALARM) || (state_d == RECOVER);
      ready_d = (state_d == RECOVER);
      event_d = raise;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= NORMAL;
         alarm_q <= 1'b0;
         event_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alarm_q <= alarm_d;
         event_q <= event_d;
         ready_q <= ready_d;
      end
   end

   assign bus.alarm      = alarm_q;
   assign bus.alarmEvent = event_q;
   assign bus.clearReady = ready_q;
   assign bus.eventCount = event_cnt;

endmodule

// File: tb/tb_temperature_alarm_controller.sv
// Directed and random stimulus for the temperature alarm controller, checked
// against a run-length reference model; a second instance with EVT_W=2
// exercises event-count saturation.
module tb_temperature_alarm_controller;
   import temperature_alarm_controller_pkg::*;

   localparam int CONF = DEF_CONFIRM_COUNT;
   localparam int CLR  = DEF_CLEAR_COUNT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   temperature_alarm_controller_if #(.EVT_W(8)) bus  ();
   temperature_alarm_controller_if #(.EVT_W(2)) bus2 ();

   temperature_alarm_controller #(
      .CONFIRM_COUNT(CONF), .CLEAR_COUNT(CLR), .CNT_W(4), .EVT_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   temperature_alarm_controller #(
      .CONFIRM_COUNT(CONF), .CLEAR_COUNT(CLR), .CNT_W(4), .EVT_W(2)
   ) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   always #5 clk = ~clk;

   // Reference model: alarm raised after CONF consecutive abnormal valid samples,
   // "ready" after CLR consecutive normal valid samples while alarmed.
   bit m_alarm, m_ready, m_pulse;
   int m_run, m_events;

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_reset();
      m_alarm = 0; m_ready = 0; m_pulse = 0; m_run = 0; m_events = 0;
   endtask

   task automatic model_edge(input bit v, input bit a, input bit k);
      m_pulse = 0;
      if (!m_alarm) begin
         if (v) begin
            if (a) begin
               m_run++;
               if (m_run == CONF) begin
                  m_alarm = 1; m_pulse = 1; m_events++; m_run = 0;
               end
            end else m_run = 0;
         end
      end else if (!m_ready) begin
         if (v) begin
            if (a) m_run = 0;
            else begin
               m_run++;
               if (m_run == CLR) begin m_ready = 1; m_run = 0; end
            end
         end
      end else begin
         if (v && a) begin m_ready = 0; m_run = 0; end
         else if (k) begin m_alarm = 0; m_ready = 0; end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".alarm"},  32'(bus.alarm),       32'(m_alarm));
      chk({tag, ".event"},  32'(bus.alarmEvent),  32'(m_pulse));
      chk({tag, ".ready"},  32'(bus.clearReady),  32'(m_ready));
      chk({tag, ".count"},  32'(bus.eventCount),  32'(sat(m_events, 255)));
      chk({tag, ".alarm2"}, 32'(bus2.alarm),      32'(m_alarm));
      chk({tag, ".count2"}, 32'(bus2.eventCount), 32'(sat(m_events, 3)));
   endtask

   task automatic step(input string tag, input bit v, input bit a, input bit k);
      bus.sampleValid  = v; bus.tempAbnormality  = a; bus.alarmAck  = k;
      bus2.sampleValid = v; bus2.tempAbnormality = a; bus2.alarmAck = k;
      @(posedge clk);
      model_edge(v, a, k);
      #1;
      chk_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk({tag, ".alarm"}, 32'(bus.alarm),      32'd0);
      chk({tag, ".event"}, 32'(bus.alarmEvent), 32'd0);
      chk({tag, ".ready"}, 32'(bus.clearReady), 32'd0);
      chk({tag, ".count"}, 32'(bus.eventCount), 32'd0);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      bit v, a, k;
      int bias;
      model_reset();
      bus.sampleValid  = 0; bus.tempAbnormality  = 0; bus.alarmAck  = 0;
      bus2.sampleValid = 0; bus2.tempAbnormality = 0; bus2.alarmAck = 0;
      #12;
      chk_all("reset");
      rst = 1'b0;

      // run broken early: no alarm
      step("t2", 1, 1, 0); step("t2", 1, 1, 0); step("t2", 1, 0, 0);
      step("t2", 1, 1, 0); step("t2", 1, 1, 0);
      chk("t2.alarm", 32'(bus.alarm), 32'd0);
      chk("t2.count", 32'(bus.eventCount), 32'd0);

      // break the pending run, then 3 abnormal samples raise
      step("t1", 1, 0, 0);
      step("t1", 1, 1, 0); step("t1", 1, 1, 0); step("t1", 1, 1, 0);
      chk("t1.alarm", 32'(bus.alarm), 32'd1);
      chk("t1.event", 32'(bus.alarmEvent), 32'd1);
      step("t1", 0, 0, 0);
      chk("t1.event_off", 32'(bus.alarmEvent), 32'd0);
      chk("t1.count", 32'(bus.eventCount), 32'd1);

      // ack held in ALARM does nothing until cleared; then releases
      step("t3", 0, 0, 1); step("t3", 1, 1, 1);
      step("t3", 1, 0, 1); step("t3", 1, 0, 1); step("t3", 1, 0, 1); step("t3", 1, 0, 1);
      chk("t3.ready", 32'(bus.clearReady), 32'd1);
      step("t3", 0, 0, 1);
      chk("t3.alarm_off", 32'(bus.alarm), 32'd0);

      // RECOVER: abnormal together with ack -> back to ALARM, no new event
      step("t4", 1, 1, 0); step("t4", 1, 1, 0); step("t4", 1, 1, 0);
      for (int i = 0; i < CLR; i++) step("t4", 1, 0, 0);
      step("t4", 1, 1, 1);
      chk("t4.alarm", 32'(bus.alarm), 32'd1);
      chk("t4.ready", 32'(bus.clearReady), 32'd0);
      chk("t4.event", 32'(bus.alarmEvent), 32'd0);
      chk("t4.count", 32'(bus.eventCount), 32'd2);
      for (int i = 0; i < CLR; i++) step("t4", 1, 0, 0);
      step("t4", 0, 0, 1);

      // gapped samples still confirm on the third valid one
      for (int s = 0; s < CONF; s++) begin
         step("t5", 1, 1, 0);
         if (s < CONF - 1) for (int g = 0; g < 5; g++) step("t5", 0, 0, 0);
      end
      chk("t5.alarm", 32'(bus.alarm), 32'd1);
      chk("t5.event", 32'(bus.alarmEvent), 32'd1);

      // async reset mid-SUSPECT and mid-ALARM
      async_reset("t6a");
      step("t6", 1, 1, 0);
      async_reset("t6s");
      for (int i = 0; i < CONF; i++) step("t6", 1, 1, 0);
      async_reset("t6m");

      // five raises: narrow counter saturates
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < CONF; i++) step("sat", 1, 1, 0);
         for (int i = 0; i < CLR; i++) step("sat", 1, 0, 0);
         step("sat", 0, 0, 1);
      end
      chk("sat.count2", 32'(bus2.eventCount), 32'd3);
      chk("sat.count", 32'(bus.eventCount), 32'd5);

      // random phase with bursty abnormality
      bias = 5;
      for (int i = 0; i < 1500; i++) begin
         if (i % 25 == 0) bias = $urandom_range(1, 9);
         v = ($urandom_range(0, 9) < 7);
         a = ($urandom_range(0, 9) < bias);
         k = ($urandom_range(0, 3) == 0);
         step("rnd", v, a, k);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
